// File: rtl/cnt_arbiter.sv
// Round-robin arbiter serialising four requesters onto a shared dual-counter datapath; optional grant statistics under CNT_ARB_STAT_EN.
// Latency: Req sampled in IDLE to Gnt is 2 cycles (ReqSlt=0) or 5 cycles (ReqSlt=1).
// Backpressure: requesters hold Req/ReqSlt until their Gnt cycle ends; Req is ignored in RUN and ACK.
module cnt_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  Req,
  input  logic [3:0]  ReqSlt,
  output logic [3:0]  Gnt,
  output logic        En,
  output logic        Slt,
  output logic        Busy
`ifdef CNT_ARB_STAT_EN
  ,
  output logic [63:0] GntCnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] win_q, win_d;
  logic       slt_q, slt_d;
  logic [2:0] burst_q, burst_d;

  logic [1:0] rr_idx;
  logic       rr_found;
  logic [1:0] rr_cand;

  // Round-robin search starting at the pointer and wrapping modulo 4.
  always_comb begin
    rr_idx   = 2'd0;
    rr_found = 1'b0;
    rr_cand  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      rr_cand = ptr_q + 2'(i);
      if (!rr_found && Req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    slt_d   = slt_q;
    burst_d = burst_q;
    En      = 1'b0;
    Slt     = 1'b0;
    Gnt     = 4'b0000;
    Busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          win_d   = rr_idx;
          slt_d   = ReqSlt[rr_idx];
          // Counter 1 advances once per four strobes, so a full burst is one increment.
          burst_d = ReqSlt[rr_idx] ? 3'd4 : 3'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        En      = 1'b1;
        Slt     = slt_q;
        burst_d = burst_q - 3'd1;
        if (burst_q == 3'd1) begin
          state_d = ACK;
        end
      end
      ACK: begin
        Gnt     = 4'b0001 << win_q;
        ptr_d   = win_q + 2'd1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      slt_q   <= 1'b0;
      burst_q <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      slt_q   <= slt_d;
      burst_q <= burst_d;
    end
  end

`ifdef CNT_ARB_STAT_EN
  logic [3:0][15:0] gnt_cnt_q, gnt_cnt_d;

  always_comb begin
    gnt_cnt_d = gnt_cnt_q;
    if (state_q == ACK && gnt_cnt_q[win_q] != 16'hFFFF) begin
      gnt_cnt_d[win_q] = gnt_cnt_q[win_q] + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      gnt_cnt_q <= '0;
    end else begin
      gnt_cnt_q <= gnt_cnt_d;
    end
  end

  assign GntCnt = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_cnt_arbiter.sv
// Directed self-checking bench for cnt_arbiter, with a behavioural model of the dual-counter datapath.
module tb_cnt_arbiter;

  logic        Clk;
  logic        Reset;
  logic [3:0]  Req;
  logic [3:0]  ReqSlt;
  logic [3:0]  Gnt;
  logic        En;
  logic        Slt;
  logic        Busy;
`ifdef CNT_ARB_STAT_EN
  logic [63:0] GntCnt;
`endif

  int n_cmp;
  int n_err;

  // Datapath model: counter 0 steps per strobe, counter 1 per four strobes.
  int         out0;
  int         out1;
  logic [1:0] phase;

  cnt_arbiter dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Req    (Req),
    .ReqSlt (ReqSlt),
    .Gnt    (Gnt),
    .En     (En),
    .Slt    (Slt),
    .Busy   (Busy)
`ifdef CNT_ARB_STAT_EN
    ,
    .GntCnt (GntCnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      out0  <= 0;
      out1  <= 0;
      phase <= 2'd0;
    end else if (En) begin
      if (!Slt) begin
        out0 <= out0 + 1;
      end else begin
        phase <= phase + 2'd1;
        if (phase == 2'd3) out1 <= out1 + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
    check("gnt_onehot0", 64'($onehot0(Gnt)), 64'd1);
  endtask

  task automatic check_strobe(input string tag, input logic slt_exp);
    check({tag, "_en"},   64'(En),   64'd1);
    check({tag, "_slt"},  64'(Slt),  slt_exp);
    check({tag, "_gnt"},  64'(Gnt),  64'd0);
    check({tag, "_busy"}, 64'(Busy), 64'd1);
  endtask

  task automatic check_ack(input string tag, input logic [3:0] gnt_exp);
    check({tag, "_gnt"},  64'(Gnt),  64'(gnt_exp));
    check({tag, "_en"},   64'(En),   64'd0);
    check({tag, "_busy"}, 64'(Busy), 64'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_en"},   64'(En),   64'd0);
    check({tag, "_gnt"},  64'(Gnt),  64'd0);
    check({tag, "_busy"}, 64'(Busy), 64'd0);
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    #1;
    check_idle("rst_async");
    check("rst_slt", 64'(Slt), 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    Reset  = 1'b0;
    Req    = 4'b0000;
    ReqSlt = 4'b0000;
    #1;
    check_idle("reset");
    check("reset_slt", 64'(Slt), 64'd0);
`ifdef CNT_ARB_STAT_EN
    check("reset_gntcnt", GntCnt, 64'd0);
`endif
    @(negedge Clk);
    Reset = 1'b1;

    // Idle with no request stays idle.
    tick();
    check_idle("no_req");

    // Single short burst to requester 0.
    Req = 4'b0001;
    tick();
    check_strobe("a_run", 1'b0);
    tick();
    check_ack("a_ack", 4'b0001);
    Req = 4'b0000;
    tick();
    check_idle("a_idle");
    check("a_out0", 64'(out0), 64'd1);
    check("a_out1", 64'(out1), 64'd0);

    // Long burst to requester 2; inputs disturbed mid-burst must not matter.
    Req    = 4'b0100;
    ReqSlt = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_strobe($sformatf("b_run%0d", k), 1'b1);
      if (k == 1) begin
        Req    = 4'b0011;
        ReqSlt = 4'b0000;
      end
    end
    tick();
    check_ack("b_ack", 4'b0100);
    Req    = 4'b0000;
    ReqSlt = 4'b0000;
    tick();
    check_idle("b_idle");
    check("b_out0", 64'(out0), 64'd1);
    check("b_out1", 64'(out1), 64'd1);
    check("b_phase", 64'(phase), 64'd0);

    // After reset the pointer favours requester 0; all four served in order.
    pulse_reset();
    Req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_strobe($sformatf("c_run%0d", k), 1'b0);
      tick();
      check_ack($sformatf("c_ack%0d", k), 4'b0001 << k);
      Req[k] = 1'b0;
      tick();
      check_idle($sformatf("c_idle%0d", k));
    end

    // Serve requester 1 so the pointer sits at 2, then 0 beats 1.
    Req = 4'b0010;
    tick();
    tick();
    check_ack("d_first", 4'b0010);
    Req = 4'b0011;
    tick();
    tick();
    check_strobe("d_run0", 1'b0);
    tick();
    check_ack("d_ack0", 4'b0001);
    Req = 4'b0010;
    tick();
    tick();
    tick();
    check_ack("d_ack1", 4'b0010);
    Req = 4'b0000;
    tick();

    // Reset during the second strobe of a long burst aborts it cleanly.
    Req    = 4'b0100;
    ReqSlt = 4'b0100;
    tick();
    check_strobe("e_run0", 1'b1);
    tick();
    check_strobe("e_run1", 1'b1);
    Req    = 4'b0000;
    ReqSlt = 4'b0000;
    pulse_reset();
    tick();
    check_idle("e_after_rst");
    check("e_phase", 64'(phase), 64'd0);
    Req    = 4'b1000;
    ReqSlt = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_strobe($sformatf("e_run_new%0d", k), 1'b1);
    end
    tick();
    check_ack("e_ack", 4'b1000);
    Req    = 4'b0000;
    ReqSlt = 4'b0000;
    tick();
    check_idle("e_idle");
    check("e_out0", 64'(out0), 64'd0);
    check("e_out1", 64'(out1), 64'd1);
`ifdef CNT_ARB_STAT_EN
    check("e_gntcnt", GntCnt, {16'd1, 48'd0});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
